// File: rtl/irq_pkg.sv
// irq_pkg: register offsets, VECT field positions, FSM state type and lowest-set-bit helper
package irq_pkg;
  localparam logic [2:0] OFS_PEND  = 3'd0;
  localparam logic [2:0] OFS_MASK  = 3'd1;
  localparam logic [2:0] OFS_LEVEL = 3'd2;
  localparam logic [2:0] OFS_EDGE  = 3'd3;
  localparam logic [2:0] OFS_VECT  = 3'd4;
  localparam logic [2:0] OFS_EOI   = 3'd5;
  localparam int VECT_V1 = 15;
  localparam int VECT_I1 = 8;
  localparam int VECT_V0 = 7;
  localparam int VECT_I0 = 0;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE} irq_state_t;
  function automatic logic [4:0] lowest_idx(input logic [15:0] v);
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) lowest_idx = 5'(i);
  endfunction
endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: core data bus and INT/INTACK handshake between core (master) and controller (slave)
interface irq_controller_if;
  logic [15:0] ADDR, WDATA, RDATA;
  logic        RDN, WRN0, WRN1, SEL;
  logic        INT0, INT1, INTACK0, INTACK1;
  modport master(output ADDR, WDATA, RDN, WRN0, WRN1, INTACK0, INTACK1,
                 input  RDATA, SEL, INT0, INT1);
  modport slave (input  ADDR, WDATA, RDN, WRN0, WRN1, INTACK0, INTACK1,
                 output RDATA, SEL, INT0, INT1);
endinterface

// File: rtl/irq_level_fsm.sv
// irq_level_fsm: one priority level's IDLE/REQ/SERVICE handshake, INTx output and in-service index
module irq_level_fsm
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [4:0]  idx,
  input  logic        block,
  input  logic        ack,
  input  logic        eoi,
  output logic        irq,
  output irq_state_t  state,
  output logic [4:0]  svc_idx,
  output logic        take
);
  assign take = state == IRQ_REQ && ack && |req;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IRQ_IDLE;
      irq     <= 1'b0;
      svc_idx <= '0;
    end else
      case (state)
        IRQ_IDLE: if (|req && !block) begin
          state <= IRQ_REQ;
          irq   <= 1'b1;
        end
        IRQ_REQ: if (!(|req) || take) begin
          state   <= take ? IRQ_SERVICE : IRQ_IDLE;
          irq     <= 1'b0;
          svc_idx <= take ? idx : svc_idx;
        end
        IRQ_SERVICE: if (eoi) state <= IRQ_IDLE;
        default: state <= IRQ_IDLE;
      endcase
endmodule

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped 16-source interrupt controller driving INT0/INT1.
// Define IRQ_NESTING_EN to let INT1 preempt an INT0 service.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  irq_controller_if.slave    bus
);
  localparam logic [15:0] VALID = 16'((32'd1 << NUM_SRC) - 32'd1);
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [15:0] pend_q, mask_q, level_q, edge_q, prev_q;
  logic [15:0] diff, wm, wr_v, sync_v, rise, w1c, ack_clr, pend_n, req0, req1, vect;
  logic [2:0]  off;
  logic [4:0]  idx0, idx1, svc0_idx, svc1_idx;
  logic        sel, wr_lo, eoi0, eoi1, take0, take1, blk0, blk1, enter1, int0, int1, unused;
  irq_state_t  st0, st1;
  assign diff    = bus.ADDR - BASE_ADDR;
  assign sel     = diff < 16'd6;
  assign off     = diff[2:0];
  assign wr_lo   = sel && !bus.WRN0;
  assign wm      = sel ? {{8{~bus.WRN1}}, {8{~bus.WRN0}}} & VALID : '0;
  assign wr_v    = bus.WDATA & wm;
  assign eoi0    = wr_lo && off == OFS_EOI && bus.WDATA[0];
  assign eoi1    = wr_lo && off == OFS_EOI && bus.WDATA[1];
  assign sync_v  = 16'(sync_q[SYNC_STAGES-1]);
  assign rise    = sync_v & ~prev_q;
  assign w1c     = off == OFS_PEND ? wr_v : '0;
  assign ack_clr = (take0 ? 16'd1 << idx0 : '0) | (take1 ? 16'd1 << idx1 : '0);
  // a fresh edge outranks a same-cycle clear so no event is lost
  assign pend_n  = ((edge_q & (rise | (pend_q & ~(w1c | ack_clr)))) | (~edge_q & sync_v)) & VALID;
  assign req1    = pend_q & mask_q & level_q;
  assign req0    = pend_q & mask_q & ~level_q;
  assign idx1    = lowest_idx(req1);
  assign idx0    = lowest_idx(req0);
  assign enter1  = st1 == IRQ_IDLE && |req1 && !blk1;
`ifdef IRQ_NESTING_EN
  assign blk1    = st1 == IRQ_SERVICE;
`else
  assign blk1    = st0 == IRQ_SERVICE || st1 == IRQ_SERVICE;
`endif
  // INT0 never starts while INT1 is pending, entering or in service
  assign blk0    = st0 == IRQ_SERVICE || st1 != IRQ_IDLE || enter1;
  always_comb begin
    vect                 = '0;
    vect[VECT_V1]        = |req1;
    vect[VECT_I1 +: 5]   = idx1;
    vect[VECT_V0]        = |req0;
    vect[VECT_I0 +: 5]   = idx0;
  end
  assign bus.RDATA = !sel              ? '0      :
                     off == OFS_PEND   ? pend_q  :
                     off == OFS_MASK   ? mask_q  :
                     off == OFS_LEVEL  ? level_q :
                     off == OFS_EDGE   ? edge_q  :
                     off == OFS_VECT   ? vect    : '0;
  assign bus.SEL   = sel;
  assign bus.INT0  = int0;
  assign bus.INT1  = int1;
  assign unused    = ^{bus.RDN, svc0_idx, svc1_idx};
  always_ff @(posedge CLK)
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      level_q <= '0;
      edge_q  <= '0;
    end else begin
      sync_q[0] <= IRQ_IN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q  <= sync_v;
      pend_q  <= pend_n;
      mask_q  <= off == OFS_MASK  ? (mask_q  & ~wm) | wr_v : mask_q;
      level_q <= off == OFS_LEVEL ? (level_q & ~wm) | wr_v : level_q;
      edge_q  <= off == OFS_EDGE  ? (edge_q  & ~wm) | wr_v : edge_q;
    end
  irq_level_fsm u_fsm0 (
    .clk(CLK), .rst(RESET), .req(req0), .idx(idx0), .block(blk0), .ack(bus.INTACK0),
    .eoi(eoi0), .irq(int0), .state(st0), .svc_idx(svc0_idx), .take(take0)
  );
  irq_level_fsm u_fsm1 (
    .clk(CLK), .rst(RESET), .req(req1), .idx(idx1), .block(blk1), .ack(bus.INTACK1),
    .eoi(eoi1), .irq(int1), .state(st1), .svc_idx(svc1_idx), .take(take1)
  );
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized level-mode register/vector checks
module tb_irq_controller;
  import irq_pkg::*;
  localparam logic [15:0] BASE = 16'hFF00;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] IRQ_IN = '0;
  int checks = 0;
  int errors = 0;
  irq_controller_if bus();
  irq_controller #(.NUM_SRC(8), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .bus(bus)
  );
  always #10 CLK = ~CLK;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic wr(input logic [2:0] o, input logic [15:0] d, input logic [1:0] bs = 2'b11);
    bus.ADDR  = BASE + {13'd0, o};
    bus.WDATA = d;
    bus.WRN0  = ~bs[0];
    bus.WRN1  = ~bs[1];
    @(negedge CLK);
    bus.WRN0  = 1'b1;
    bus.WRN1  = 1'b1;
  endtask
  task automatic rd_at(input logic [15:0] a, input logic [15:0] exp, input logic [15:0] m, input string tag);
    bus.ADDR = a;
    bus.RDN  = 1'b0;
    #1 chk(tag, bus.RDATA & m, exp);
    bus.RDN  = 1'b1;
  endtask
  task automatic rd(input logic [2:0] o, input logic [15:0] exp, input string tag, input logic [15:0] m = 16'hFFFF);
    rd_at(BASE + {13'd0, o}, exp, m, tag);
  endtask
  task automatic sel_chk(input logic [15:0] a, input logic exp, input string tag);
    bus.ADDR = a;
    #1 chk1(tag, bus.SEL, exp);
  endtask
  task automatic ack(input logic lvl);
    if (lvl) bus.INTACK1 = 1'b1; else bus.INTACK0 = 1'b1;
    @(negedge CLK);
    bus.INTACK0 = 1'b0;
    bus.INTACK1 = 1'b0;
  endtask
  function automatic logic [4:0] first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] m_mask, m_level, d, wmask, exp_vect;
    logic [7:0]  irqv, r0, r1;
    logic [1:0]  bs;
    bus.ADDR = '0; bus.WDATA = '0; bus.RDN = 1'b1; bus.WRN0 = 1'b1; bus.WRN1 = 1'b1;
    bus.INTACK0 = 1'b0; bus.INTACK1 = 1'b0;
    step(3);
    RESET = 1'b0;
    step(1);
    rd(OFS_PEND, 16'h0, "rst_pend");
    rd(OFS_MASK, 16'h0, "rst_mask");
    rd(OFS_LEVEL, 16'h0, "rst_level");
    rd(OFS_EDGE, 16'h0, "rst_edge");
    rd(OFS_VECT, 16'h0, "rst_vect");
    chk1("rst_int0", bus.INT0, 1'b0);
    chk1("rst_int1", bus.INT1, 1'b0);
    sel_chk(16'hFEFF, 1'b0, "sel_below");
    sel_chk(16'hFF00, 1'b1, "sel_base");
    sel_chk(16'hFF05, 1'b1, "sel_top");
    sel_chk(16'hFF06, 1'b0, "sel_above");
    // single edge source on INT0
    wr(OFS_MASK, 16'h0004);
    wr(OFS_EDGE, 16'h0004);
    IRQ_IN = 8'h04;
    step(2);
    rd(OFS_PEND, 16'h0000, "t2_pend_early");
    step(1);
    rd(OFS_PEND, 16'h0004, "t2_pend_latency");
    IRQ_IN = 8'h00;
    step(1);
    chk1("t2_int0", bus.INT0, 1'b1);
    rd(OFS_VECT, 16'h0082, "t2_vect");
    ack(1'b0);
    rd(OFS_PEND, 16'h0000, "t2_pend_ack");
    chk1("t2_int0_ack", bus.INT0, 1'b0);
    wr(OFS_EOI, 16'h0001);
    IRQ_IN = 8'h04;
    step(1);
    IRQ_IN = 8'h00;
    step(3);
    chk1("t2_reentry", bus.INT0, 1'b1);
    ack(1'b0);
    wr(OFS_EOI, 16'h0001);
    // simultaneous INT1 and INT0 sources
    wr(OFS_EDGE, 16'h00FF);
    wr(OFS_MASK, 16'h00FF);
    wr(OFS_LEVEL, 16'h0080);
    IRQ_IN = 8'h82;
    step(1);
    IRQ_IN = 8'h00;
    step(3);
    chk1("t3_int1", bus.INT1, 1'b1);
    chk1("t3_int0_blocked", bus.INT0, 1'b0);
    rd(OFS_VECT, 16'h8700, "t3_vect_hi", 16'hFF00);
    step(1);
    chk1("t3_int0_still", bus.INT0, 1'b0);
    ack(1'b1);
    chk1("t3_int1_ack", bus.INT1, 1'b0);
    rd(OFS_PEND, 16'h0002, "t3_pend_after_ack");
    step(1);
    chk1("t3_int0_svc_block", bus.INT0, 1'b0);
    wr(OFS_EOI, 16'h0002);
    step(1);
    chk1("t3_int0_after_eoi", bus.INT0, 1'b1);
    rd(OFS_VECT, 16'h0081, "t3_vect_lo", 16'h00FF);
    ack(1'b0);
    wr(OFS_EOI, 16'h0001);
    // set beats a coincident W1C
    IRQ_IN = 8'h08;
    step(2);
    wr(OFS_PEND, 16'h0008);
    rd(OFS_PEND, 16'h0008, "t4_set_wins");
    IRQ_IN = 8'h00;
    wr(OFS_PEND, 16'h0008);
    rd(OFS_PEND, 16'h0000, "t4_w1c");
    step(2);
    chk1("t4_int0_drop", bus.INT0, 1'b0);
    // level mode, mask withdrawn before ack
    wr(OFS_LEVEL, 16'h0000);
    wr(OFS_EDGE, 16'h0000);
    wr(OFS_MASK, 16'h0001);
    IRQ_IN = 8'h01;
    step(4);
    chk1("t5_int0", bus.INT0, 1'b1);
    rd(OFS_PEND, 16'h0001, "t5_pend");
    wr(OFS_MASK, 16'h0000);
    step(1);
    chk1("t5_int0_masked", bus.INT0, 1'b0);
    rd(OFS_PEND, 16'h0001, "t5_pend_kept");
    wr(OFS_PEND, 16'h0001);
    rd(OFS_PEND, 16'h0001, "t5_w1c_ignored");
    IRQ_IN = 8'h00;
    step(3);
    rd(OFS_PEND, 16'h0000, "t5_pend_follows");
    // register width and byte strobes
    wr(OFS_MASK, 16'hFFFF);
    rd(OFS_MASK, 16'h00FF, "mask_upper_zero");
    rd_at(16'hFF09, 16'h0000, 16'hFFFF, "rdata_outside");
    wr(OFS_MASK, 16'h0000, 2'b10);
    rd(OFS_MASK, 16'h00FF, "mask_hi_strobe");
    wr(OFS_MASK, 16'hFF00, 2'b01);
    rd(OFS_MASK, 16'h0000, "mask_lo_strobe");
    // INT1 raised during INT0 service, then reset mid-service
    wr(OFS_LEVEL, 16'h0010);
    wr(OFS_EDGE, 16'h0011);
    wr(OFS_MASK, 16'h0011);
    IRQ_IN = 8'h01;
    step(1);
    IRQ_IN = 8'h00;
    step(3);
    chk1("t6_int0", bus.INT0, 1'b1);
    ack(1'b0);
    IRQ_IN = 8'h10;
    step(1);
    IRQ_IN = 8'h00;
    step(4);
    rd(OFS_PEND, 16'h0010, "t6_pend");
`ifdef IRQ_NESTING_EN
    chk1("t6_int1_nested", bus.INT1, 1'b1);
`else
    chk1("t6_int1_blocked", bus.INT1, 1'b0);
    wr(OFS_EOI, 16'h0001);
    step(1);
    chk1("t6_int1_after_eoi", bus.INT1, 1'b1);
`endif
    ack(1'b1);
    chk1("t6_int1_ack", bus.INT1, 1'b0);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    rd(OFS_PEND, 16'h0, "t6_rst_pend");
    rd(OFS_MASK, 16'h0, "t6_rst_mask");
    rd(OFS_LEVEL, 16'h0, "t6_rst_level");
    rd(OFS_EDGE, 16'h0, "t6_rst_edge");
    chk1("t6_rst_int0", bus.INT0, 1'b0);
    chk1("t6_rst_int1", bus.INT1, 1'b0);
    wr(OFS_MASK, 16'h0004);
    wr(OFS_EDGE, 16'h0004);
    IRQ_IN = 8'h04;
    step(1);
    IRQ_IN = 8'h00;
    step(3);
    chk1("t6_post_reset_int0", bus.INT0, 1'b1);
    ack(1'b0);
    wr(OFS_EOI, 16'h0001);
    // randomized level-mode routing against a register/vector model
    wr(OFS_EDGE, 16'h0000);
    wr(OFS_MASK, 16'h0000);
    wr(OFS_LEVEL, 16'h0000);
    m_mask  = '0;
    m_level = '0;
    for (int n = 0; n < 25; n++) begin
      d = 16'($urandom);
      bs = 2'($urandom);
      wr(OFS_MASK, d, bs);
      wmask = {{8{bs[1]}}, {8{bs[0]}}} & 16'h00FF;
      m_mask = (m_mask & ~wmask) | (d & wmask);
      d = 16'($urandom);
      bs = 2'($urandom);
      wr(OFS_LEVEL, d, bs);
      wmask = {{8{bs[1]}}, {8{bs[0]}}} & 16'h00FF;
      m_level = (m_level & ~wmask) | (d & wmask);
      irqv = 8'($urandom);
      IRQ_IN = irqv;
      step(6);
      r1 = irqv & m_mask[7:0] & m_level[7:0];
      r0 = irqv & m_mask[7:0] & ~m_level[7:0];
      exp_vect = {(r1 != 0), 2'b00, first_set(r1), (r0 != 0), 2'b00, first_set(r0)};
      rd(OFS_MASK, m_mask, "rnd_mask");
      rd(OFS_LEVEL, m_level, "rnd_level");
      rd(OFS_PEND, {8'h00, irqv}, "rnd_pend");
      rd(OFS_VECT, exp_vect, "rnd_vect");
      chk1("rnd_int1", bus.INT1, r1 != 0);
      if (r1 == 0) chk1("rnd_int0", bus.INT0, r0 != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller directly upstream of the core; drives the core's INT0 (low priority) and INT1 (high priority) request inputs.
- Synchronises up to 16 external sources and latches edges into a pending register.
- Applies mask and per-source level routing, and runs a per-level request/service handshake with the core.
- Programmed and read through the core's 16-bit data bus, using its active-low read and byte-write strobes.

Parameters:
- NUM_SRC, 8: number of IRQ sources, 1..16.
- BASE_ADDR, 16'hFF00: word-aligned base address of the register window (offsets 0..5).
- SYNC_STAGES, 2: synchroniser depth per source, minimum 2.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- IRQ_IN  in  NUM_SRC  asynchronous external interrupt sources.
- ADDR  in  16  core address bus (ADDR_BUF).
- WDATA  in  16  core write data (DOUT_BUF).
- RDN  in  1  active-low read strobe.
- WRN0  in  1  active-low low-byte write.
- WRN1  in  1  active-low high-byte write.
- RDATA  out  16  read data; combinational, valid in the same cycle.
- SEL  out  1  address hit, used by the external DIN mux.
- INT0  out  1  low-priority request to the core.
- INT1  out  1  high-priority request to the core.
- INTACK0  in  1  one-cycle pulse from the core when it vectors on INT0.
- INTACK1  in  1  one-cycle pulse from the core when it vectors on INT1.

Behaviour:
- Register window, word offsets from BASE_ADDR; SEL = address in window.
  - 0 PEND: read; write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 LEVEL: read/write; 1 = route to INT1.
  - 3 EDGE: read/write; 1 = rising-edge, 0 = level.
  - 4 VECT: read-only; [12:8] = INT1 source index, [4:0] = INT0 source index, bit 15 = INT1 valid, bit 7 = INT0 valid.
  - 5 EOI: write-only; bit0 ends INT0 service, bit1 ends INT1 service.
- Writes take effect on the CLK edge where the WRNx strobe is low and SEL is high. WRN0 writes [7:0]; WRN1 writes [15:8].
- Bits at or above NUM_SRC read 0 and ignore writes.
- Reads have no side effects. RDATA = 0 when SEL is low.
- Source path: SYNC_STAGES-flop synchroniser, then a registered previous value for edge detection.
  - Latency from IRQ_IN to PEND is SYNC_STAGES+1 cycles.
  - Edge mode: PEND bit sets on a synchronised 0->1 transition.
  - Edge mode, simultaneous set and W1C: set wins.
  - Level mode: PEND bit follows the synchronised level; W1C has no effect.
- Per-level request vector: REQx = PEND & MASK & (LEVEL for x=1, ~LEVEL for x=0). The VECT index is the lowest set bit of REQx.
- Per-level FSM, states IDLE, REQ, SERVICE:
  - IDLE -> REQ when |REQx and the level is not blocked. INTx is registered, high only in REQ.
  - REQ -> SERVICE on INTACKx. The acknowledged source's PEND bit clears in that same cycle (edge mode only), and its index is latched as in-service.
  - REQ -> IDLE if REQx drops to 0 before the ack (masked or cleared). INTx deasserts.
  - SERVICE -> IDLE on an EOI write with the matching bit set.
  - INTACKx outside REQ is ignored. EOI outside SERVICE is ignored.
- Blocking (without the optional feature): either level in SERVICE blocks both levels from entering REQ.
  - If both levels would enter REQ in the same cycle, only INT1 asserts.
  - If INT0 is already in REQ when INT1 enters REQ, INT0 remains in REQ.
- Reset: all registers 0 (all sources masked, INT0-routed, level mode), both FSMs IDLE, INT0 = INT1 = 0. Synchroniser flops are cleared.
- Reset asserted mid-service returns to IDLE; no EOI is needed afterwards.

Optional Feature:
- Macro IRQ_NESTING_EN.
- Defined: INT0 in SERVICE blocks only INT0. INT1 may enter REQ and SERVICE, preempting INT0. INT1 in SERVICE blocks both levels. VECT reports both levels independently.
- Undefined: strict single-service behaviour as above.

Decomposition:
- Package irq_pkg holds:
  - register offset localparams (OFS_PEND..OFS_EOI);
  - typedef enum irq_state_t {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE};
  - the VECT field positions.
- Sub-module irq_level_fsm, instantiated twice, owns:
  - state, INTx generation and the in-service index;
  - inputs: req vector, block, ack, eoi.
- Top level owns synchronisers, registers, priority encode, read mux and blocking logic.

Test Plan:
1. Reset, then read offsets 0..4 -> all 0x0000; INT0 = INT1 = 0; SEL = 1 only for 0xFF00..0xFF05.
2. MASK = 0x0004, EDGE = 0x0004; pulse IRQ_IN[2] -> PEND = 0x0004 after 3 cycles, INT0 = 1 next cycle, VECT = 0x0082. INTACK0 -> PEND = 0, INT0 = 0. EOI = 0x0001 -> FSM IDLE.
3. EDGE = 0x00FF, MASK = 0x00FF, LEVEL = 0x0080; edge on IRQ_IN[7] and IRQ_IN[1] in the same cycle -> only INT1 asserts, VECT bit15 = 1, index 7. After INTACK1 and EOI bit1 -> INT0 asserts with index 1.
4. Edge on IRQ_IN[3] coincident with a W1C write of 0x0008 to PEND -> PEND[3] remains 1.
5. Level mode, IRQ_IN[0] held high, MASK = 0x0001 -> INT0 = 1. Write MASK = 0 before INTACK0 -> INT0 = 0 next cycle, PEND[0] still 1.
6. INT0 in SERVICE, raise an INT1 source -> without IRQ_NESTING_EN, INT1 stays 0 until EOI bit0; with IRQ_NESTING_EN, INT1 asserts. A mid-service RESET pulse clears everything.
